ins_l2_refill_engine: RTL and testbench
=======================================

INS_L2_REFILL_ENGINE -- requirements
Module: ins_l2_refill_engine

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width; L1/L2 word address is ADDRESS_WIDTH-2 bits.
REQ-002 SHALL have parameter L2_BUS_WIDTH, default 128, beat width in bits (4 instruction words).
REQ-003 SHALL have parameter BEATS_PER_BLOCK, default 4, beats per 64-byte line; power of two >= 2.
REQ-004 SHALL have ports CLK in 1 (sole clock) and RST in 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports ADDRESS_TO_L2_VALID_INS in 1, ADDRESS_TO_L2_READY_INS out 1 and ADDRESS_TO_L2_INS in ADDRESS_WIDTH-2, the miss-request word address from the instruction cache.
REQ-006 SHALL have ports DATA_FROM_L2_VALID_INS out 1, DATA_FROM_L2_READY_INS in 1 and DATA_FROM_L2_INS out L2_BUS_WIDTH, the refill beat to the instruction cache.
REQ-007 SHALL have ports MEM_READ_VALID out 1, MEM_READ_READY in 1 and MEM_READ_ADDRESS out ADDRESS_WIDTH-2, the beat-aligned word address to backing memory.
REQ-008 SHALL have ports MEM_DATA_VALID in 1 and MEM_DATA in L2_BUS_WIDTH, the in-order read return from memory, with no backpressure.

Function
REQ-009 SHALL be a 3-state FSM: IDLE, ISSUE, DRAIN.
REQ-010 In IDLE, SHALL drive ADDRESS_TO_L2_READY_INS=1; a VALID&READY cycle SHALL latch the address and move to ISSUE on the next edge.
REQ-011 SHALL drive ADDRESS_TO_L2_READY_INS=0 in ISSUE and DRAIN, so at most one line refill is in flight.
REQ-012 Word address fields: word-in-beat = addr[1:0], beat index = addr[3:2], block base = addr[29:4].
REQ-013 ISSUE SHALL send BEATS_PER_BLOCK requests, critical beat first, then wrapping modulo BEATS_PER_BLOCK (e.g. beat 2 gives order 2,3,0,1).
REQ-014 Each request address SHALL be {block base, beat index, 2'b00}.
REQ-015 MEM_READ_VALID SHALL be high throughout ISSUE; the issue counter SHALL advance only on MEM_READ_VALID&MEM_READ_READY.
REQ-016 MEM_READ_ADDRESS SHALL hold stable while MEM_READ_VALID=1 and MEM_READ_READY=0.
REQ-017 After the last request is accepted, the FSM SHALL enter DRAIN.
REQ-018 Each MEM_DATA_VALID beat SHALL be written into a BEATS_PER_BLOCK-deep FIFO. Returns may arrive during ISSUE, and in the same cycle as a request handshake.
REQ-019 The FIFO SHALL never overflow, because outstanding requests are bounded by BEATS_PER_BLOCK per line.
REQ-020 DATA_FROM_L2_VALID_INS SHALL equal FIFO-not-empty, and DATA_FROM_L2_INS SHALL equal the FIFO head (registered output, 1-cycle minimum latency from MEM_DATA_VALID).
REQ-021 A VALID&READY cycle on the L1 side SHALL pop the FIFO head.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged, including at full and at empty.
REQ-023 Beats SHALL reach the L1 side in issue order, i.e. critical beat first.
REQ-024 DRAIN SHALL return to IDLE in the cycle after the final beat (the BEATS_PER_BLOCK-th) is popped.
REQ-025 A new request SHALL be accepted no earlier than the cycle after that return to IDLE.
REQ-026 Beat counters SHALL be $clog2(BEATS_PER_BLOCK) bits and wrap naturally.
REQ-027 MEM_DATA_VALID asserted while in IDLE SHALL be ignored.

Reset
REQ-028 On RST assertion, the FSM SHALL go asynchronously to IDLE.
REQ-029 On RST assertion, the FIFO pointers, occupancy and counters SHALL clear to 0.
REQ-030 On RST assertion, outputs SHALL become ADDRESS_TO_L2_READY_INS=1, MEM_READ_VALID=0, DATA_FROM_L2_VALID_INS=0, MEM_READ_ADDRESS=0 and DATA_FROM_L2_INS=0.
REQ-031 RST mid-refill SHALL discard all in-flight beats; memory returns for the aborted line arriving after RST deasserts SHALL be dropped while in IDLE.
REQ-032 FIFO data storage need not be reset.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the L2 bus width and the beats-per-block constant.
REQ-034 The beat FIFO SHALL be a separate sub-module, beat_fifo (parameters WIDTH, DEPTH).
REQ-035 No memory macro SHALL be used; storage SHALL be flops.

Verification
REQ-036 Aligned miss: request 0x0000_0100, MEM_READ_READY=1, memory latency 2 -> MEM_READ_ADDRESS 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 beats delivered in that order; back to IDLE.
REQ-037 Critical-beat wrap: request 0x0000_01FA (beat 2) -> request order 0x1F8, 0x1FC, 0x1F0, 0x1F4; beats returned in the same order.
REQ-038 L1 backpressure: DATA_FROM_L2_READY_INS=0 until all 4 beats have returned -> FIFO full, no loss; then READY=1 -> 4 pops on consecutive cycles.
REQ-039 Memory stall: MEM_READ_READY low for 3 cycles on the second request -> address stable, no duplicate request, exactly 4 handshakes.
REQ-040 Simultaneous push and pop at occupancy 1 -> occupancy stays 1 and data order is preserved.
REQ-041 RST asserted in ISSUE after 2 requests -> outputs immediately at reset values; late returns ignored; the next request is served correctly.

Source files
------------

// File: rtl/ins_l2_refill_engine_pkg.sv
// Shared definitions for the instruction-side L2 refill engine:
// FSM encoding, default bus geometry and the word-in-beat field width.
package ins_l2_refill_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } refill_state_t;

  localparam int unsigned L2_BUS_WIDTH_DEF    = 128;
  localparam int unsigned BEATS_PER_BLOCK_DEF = 4;
  localparam int unsigned WORD_BITS           = 2;

endpackage

// File: rtl/ins_l2_refill_engine_beat_fifo.sv
// Flop-based beat FIFO; head is presented as soon as occupancy is non-zero
// and the data output is forced to zero while empty.
module beat_fifo
  import ins_l2_refill_engine_pkg::*;
#(
  parameter int unsigned WIDTH = L2_BUS_WIDTH_DEF,
  parameter int unsigned DEPTH = BEATS_PER_BLOCK_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & (r_count != '0);
  // A pop in the same cycle frees the slot, so push at full is still legal.
  assign w_do_push = i_push & ((r_count != CNT_FULL) | w_do_pop);
  assign o_valid   = (r_count != '0);
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage write port; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ins_l2_refill_engine.sv
// Instruction-cache line refill engine: accepts one miss at a time, issues
// the line's beats critical-first to memory and streams returns through a FIFO.
module ins_l2_refill_engine
  import ins_l2_refill_engine_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned L2_BUS_WIDTH    = L2_BUS_WIDTH_DEF,
  parameter int unsigned BEATS_PER_BLOCK = BEATS_PER_BLOCK_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
  output logic                     MEM_READ_VALID,
  input  logic                     MEM_READ_READY,
  output logic [ADDRESS_WIDTH-3:0] MEM_READ_ADDRESS,
  input  logic                     MEM_DATA_VALID,
  input  logic [L2_BUS_WIDTH-1:0]  MEM_DATA
);

  localparam int unsigned WAW    = ADDRESS_WIDTH - 2;
  localparam int unsigned BB     = $clog2(BEATS_PER_BLOCK);
  localparam int unsigned BASE_W = WAW - WORD_BITS - BB;
  localparam logic [BB-1:0] LAST_BEAT = BB'(BEATS_PER_BLOCK - 1);
  localparam logic [BB-1:0] ONE_BEAT  = BB'(1);

  refill_state_t     r_state;
  refill_state_t     w_next_state;
  logic [BASE_W-1:0] r_base;
  logic [BB-1:0]     r_crit;
  logic [BB-1:0]     r_issue_cnt;
  logic [BB-1:0]     r_pop_cnt;
  logic [BB-1:0]     w_beat;
  logic              w_req_hs;
  logic              w_mem_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_valid;
  logic              w_unused;

  assign ADDRESS_TO_L2_READY_INS = (r_state == ST_IDLE);
  assign MEM_READ_VALID          = (r_state == ST_ISSUE);
  assign w_req_hs = ADDRESS_TO_L2_VALID_INS & ADDRESS_TO_L2_READY_INS;
  assign w_mem_hs = MEM_READ_VALID & MEM_READ_READY;
  // Returns for an aborted line may still trickle in after reset; drop them in IDLE.
  assign w_push   = MEM_DATA_VALID & (r_state != ST_IDLE);
  assign w_pop    = DATA_FROM_L2_READY_INS & w_fifo_valid;
  assign w_beat   = r_crit + r_issue_cnt;
  assign MEM_READ_ADDRESS = MEM_READ_VALID ? {r_base, w_beat, {WORD_BITS{1'b0}}} : '0;
  assign DATA_FROM_L2_VALID_INS = w_fifo_valid;
  assign w_unused = &{1'b0, ADDRESS_TO_L2_INS[WORD_BITS-1:0]};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_hs) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_mem_hs && (r_issue_cnt == LAST_BEAT)) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (w_pop && (r_pop_cnt == LAST_BEAT)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Line address capture and beat counters; counters wrap modulo the line size.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_base      <= '0;
      r_crit      <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
    end else if (w_req_hs) begin
      r_base      <= ADDRESS_TO_L2_INS[WAW-1 -: BASE_W];
      r_crit      <= ADDRESS_TO_L2_INS[WORD_BITS +: BB];
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
    end else begin
      if (w_mem_hs) begin
        r_issue_cnt <= r_issue_cnt + ONE_BEAT;
      end
      if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + ONE_BEAT;
      end
    end
  end

  beat_fifo #(
    .WIDTH (L2_BUS_WIDTH),
    .DEPTH (BEATS_PER_BLOCK)
  ) u_beat_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (MEM_DATA),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (DATA_FROM_L2_INS)
  );

endmodule

// File: tb/tb_ins_l2_refill_engine.sv
// Self-checking bench for ins_l2_refill_engine: randomized handshakes against a
// line-level reference model (expected request order and beat order per miss).
module tb_ins_l2_refill_engine;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ADDRESS_TO_L2_VALID_INS = 1'b0;
  logic         ADDRESS_TO_L2_READY_INS;
  logic [29:0]  ADDRESS_TO_L2_INS = '0;
  logic         DATA_FROM_L2_VALID_INS;
  logic         DATA_FROM_L2_READY_INS = 1'b0;
  logic [127:0] DATA_FROM_L2_INS;
  logic         MEM_READ_VALID;
  logic         MEM_READ_READY = 1'b0;
  logic [29:0]  MEM_READ_ADDRESS;
  logic         MEM_DATA_VALID = 1'b0;
  logic [127:0] MEM_DATA = '0;

  ins_l2_refill_engine dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
    .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
    .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
    .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
    .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
    .DATA_FROM_L2_INS        (DATA_FROM_L2_INS),
    .MEM_READ_VALID          (MEM_READ_VALID),
    .MEM_READ_READY          (MEM_READ_READY),
    .MEM_READ_ADDRESS        (MEM_READ_ADDRESS),
    .MEM_DATA_VALID          (MEM_DATA_VALID),
    .MEM_DATA                (MEM_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [29:0] a;
    int          due;
  } mem_ent_t;

  mem_ent_t     mem_q[$];
  logic [29:0]  exp_req[$];
  logic [127:0] exp_beats[$];

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int last_due = 0;
  bit busy = 0;
  bit req_pend = 0;
  int issued = 0;
  int returned = 0;
  int popped = 0;
  int occ = 0;
  logic [29:0] req_addr = '0;
  int mr_mode = 0;   // 0 always ready, 1 random, 2 stall second request 3 cycles
  int l1_mode = 0;   // 0 always ready, 1 hold until line returned, 2 random
  int lat_mode = 0;  // 0 fixed 2, 1 random 1..5, 2 fixed 1, 3 fixed 6
  int stall_cnt = 0;
  bit held = 0;
  logic [29:0] held_addr = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] data_of(input logic [29:0] a);
    logic [31:0] w;
    w = {2'b00, a};
    return {w ^ 32'hA5A5_0F0F, ~w, w * 32'd3, w + 32'h1234_5678};
  endfunction

  // One clock: compare outputs with the model, drive inputs, account handshakes.
  task automatic step();
    logic [29:0] ea;
    mem_ent_t    me;
    int          lat;
    int          crit;
    if (held) check("m_hold", MEM_READ_ADDRESS, held_addr);
    check("a_rdy", ADDRESS_TO_L2_READY_INS, !busy);
    check("m_vld", MEM_READ_VALID, busy && issued < 4);
    check("d_vld", DATA_FROM_L2_VALID_INS, occ != 0);

    if (req_pend) begin
      ADDRESS_TO_L2_VALID_INS = 1'b1;
      ADDRESS_TO_L2_INS = req_addr;
    end else begin
      ADDRESS_TO_L2_VALID_INS = busy && ($urandom_range(0, 3) == 0);
      ADDRESS_TO_L2_INS = 30'($urandom);
    end
    case (mr_mode)
      0: MEM_READ_READY = 1'b1;
      1: MEM_READ_READY = ($urandom_range(0, 3) != 0);
      default: begin
        MEM_READ_READY = 1'b1;
        if (MEM_READ_VALID && issued == 1 && stall_cnt < 3) begin
          MEM_READ_READY = 1'b0;
          stall_cnt++;
        end
      end
    endcase
    case (l1_mode)
      0: DATA_FROM_L2_READY_INS = 1'b1;
      1: DATA_FROM_L2_READY_INS = (returned >= 4);
      default: DATA_FROM_L2_READY_INS = ($urandom_range(0, 2) != 0);
    endcase
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      MEM_DATA_VALID = 1'b1;
      MEM_DATA = data_of(mem_q[0].a);
    end else begin
      MEM_DATA_VALID = 1'b0;
      MEM_DATA = {$urandom, $urandom, $urandom, $urandom};
    end

    if (MEM_DATA_VALID) begin
      me = mem_q.pop_front();
      if (busy) begin
        occ++;
        returned++;
      end
    end
    if (MEM_READ_VALID && MEM_READ_READY) begin
      if (exp_req.size() == 0) begin
        check("m_extra", 1'b1, 1'b0);
      end else begin
        ea = exp_req.pop_front();
        check("m_addr", MEM_READ_ADDRESS, ea);
      end
      case (lat_mode)
        0: lat = 2;
        1: lat = $urandom_range(1, 5);
        2: lat = 1;
        default: lat = 6;
      endcase
      me.a = MEM_READ_ADDRESS;
      me.due = cyc + lat;
      if (me.due <= last_due) me.due = last_due + 1;
      last_due = me.due;
      mem_q.push_back(me);
      issued++;
    end
    held = MEM_READ_VALID && !MEM_READ_READY;
    held_addr = MEM_READ_ADDRESS;
    if (DATA_FROM_L2_VALID_INS && DATA_FROM_L2_READY_INS) begin
      if (exp_beats.size() == 0) begin
        check("d_extra", 1'b1, 1'b0);
      end else begin
        check("d_data", DATA_FROM_L2_INS, exp_beats.pop_front());
      end
      if (occ > 0) occ--;
      popped++;
      if (popped == 4) busy = 0;
    end
    if (ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_READY_INS) begin
      busy = 1;
      issued = 0;
      popped = 0;
      returned = 0;
      req_pend = 0;
      stall_cnt = 0;
      crit = int'((ADDRESS_TO_L2_INS >> 2) & 30'd3);
      for (int k = 0; k < 4; k++) begin
        ea = (ADDRESS_TO_L2_INS & ~30'hF) + 30'(((crit + k) % 4) * 4);
        exp_req.push_back(ea);
        exp_beats.push_back(data_of(ea));
      end
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic run_line(input logic [29:0] a);
    int budget;
    bit started;
    req_addr = a;
    req_pend = 1;
    started = 0;
    budget = 0;
    while (budget < 300 && !(started && !busy)) begin
      step();
      if (busy) started = 1;
      budget++;
    end
    check("line_done", started && !busy, 1'b1);
    check("n_req", issued, 4);
    check("n_pop", popped, 4);
  endtask

  task automatic reset_mid_issue(input logic [29:0] a);
    int budget;
    req_addr = a;
    req_pend = 1;
    budget = 0;
    while (budget < 100 && !(busy && issued == 2)) begin
      step();
      budget++;
    end
    check("rst_reach", busy && issued == 2, 1'b1);
    RST = 1'b1;
    #1;
    check("rst_a_rdy", ADDRESS_TO_L2_READY_INS, 1'b1);
    check("rst_m_vld", MEM_READ_VALID, 1'b0);
    check("rst_d_vld", DATA_FROM_L2_VALID_INS, 1'b0);
    check("rst_m_addr", MEM_READ_ADDRESS, '0);
    check("rst_d_data", DATA_FROM_L2_INS, '0);
    busy = 0;
    issued = 0;
    popped = 0;
    returned = 0;
    occ = 0;
    req_pend = 0;
    held = 0;
    exp_req.delete();
    exp_beats.delete();
    repeat (3) step();
    RST = 1'b0;
    budget = 0;
    // Late returns of the aborted line must land while idle and be dropped.
    while (budget < 50 && mem_q.size() != 0) begin
      step();
      budget++;
    end
    check("late_drained", mem_q.size(), 0);
    step();
    step();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("por_a_rdy", ADDRESS_TO_L2_READY_INS, 1'b1);
    check("por_m_vld", MEM_READ_VALID, 1'b0);
    check("por_d_vld", DATA_FROM_L2_VALID_INS, 1'b0);
    check("por_m_addr", MEM_READ_ADDRESS, '0);
    check("por_d_data", DATA_FROM_L2_INS, '0);
    RST = 1'b0;
    step();

    // Aligned miss, then critical-beat wrap.
    mr_mode = 0; l1_mode = 0; lat_mode = 0;
    run_line(30'h100);
    run_line(30'h1FA);
    // L1 backpressure until the whole line is buffered.
    l1_mode = 1;
    run_line(30'h2C4);
    // Memory stall on the second request.
    mr_mode = 2; l1_mode = 0;
    run_line(30'h3_0008);
    // One-cycle latency with ready L1: push and pop together at occupancy 1.
    mr_mode = 0; lat_mode = 2;
    run_line(30'h55);
    // Reset in the middle of issue, late returns, then a clean refill.
    lat_mode = 3;
    reset_mid_issue(30'h777);
    lat_mode = 0;
    run_line(30'h777);

    for (int i = 0; i < 30; i++) begin
      mr_mode = $urandom_range(0, 2);
      l1_mode = $urandom_range(0, 2);
      lat_mode = $urandom_range(0, 2);
      run_line(30'($urandom));
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
